// File: rtl/hs4_pkg.sv
// Shared types and constants for the 4-phase handshake receiver.
package hs4_pkg;

    // Receiver handshake FSM states.
    typedef enum logic [1:0] {
        StArm,
        StIdle,
        StHold,
        StRelease
    } hs_state_e;

    localparam int unsigned DefDataW = 3;
    localparam int unsigned TokCntW  = 16;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy and zero-initialised storage.
module sync_fifo #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              push_en, pop_en;

    assign full     = (level_q == LvlW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state: guarded push/pop, pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        push_en  = push && !full;
        pop_en   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // State registers; storage cleared on reset so the head never shows X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/hs4_rx_sync.sv
// Clocked terminator for a 4-phase bundled-data channel: synchronises req,
// captures data into a FIFO, returns ack, and presents tokens as valid/ready.
module hs4_rx_sync
    import hs4_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hs_req,
    input  logic [DATA_W-1:0]             hs_data,
    output logic                          hs_ack,
    output logic                          m_valid,
    output logic [DATA_W-1:0]             m_data,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [TokCntW-1:0]            tok_cnt
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    // Tracks how many fresh samples have entered the synchroniser since reset.
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   req_s;
    logic                   sync_valid;

    hs_state_e              state_q, state_d;
    logic                   ack_q, ack_d;
    logic [TokCntW-1:0]     tok_cnt_q, tok_cnt_d;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign req_s      = sync_q[SYNC_STAGES-1];
    assign sync_valid = fill_q[SYNC_STAGES-1];
    assign sync_d     = {sync_q[SYNC_STAGES-2:0], hs_req};
    assign fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};

    assign hs_ack  = ack_q;
    assign tok_cnt = tok_cnt_q;
    assign m_valid = !fifo_empty;

    // Handshake FSM: accept on req rise when not full, hold ack until req falls.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        tok_cnt_d = tok_cnt_q;
        unique case (state_q)
            // The reset synchroniser reads 0, so only trust req_s once refilled;
            // otherwise a req held high across reset would look like a new token.
            StArm: begin
                if (sync_valid && !req_s) state_d = StIdle;
            end
            StIdle: begin
                if (req_s && !fifo_full) begin
                    push      = 1'b1;
                    tok_cnt_d = tok_cnt_q + 1'b1;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (!req_s) state_d = StRelease;
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: state_d = StArm;
        endcase
        ack_d = (state_d == StHold);
    end

    // Synchroniser, FSM, ack and token counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            fill_q    <= '0;
            state_q   <= StArm;
            ack_q     <= 1'b0;
            tok_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            ack_q     <= ack_d;
            tok_cnt_q <= tok_cnt_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (hs_data),
        .pop       (m_ready),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_hs4_rx_sync.sv
// Directed and randomised checks for the 4-phase receiver.
module tb_hs4_rx_sync;

    logic        clk;
    logic        rst;
    logic        hs_req;
    logic [2:0]  hs_data;
    logic        hs_ack;
    logic        m_valid;
    logic [2:0]  m_data;
    logic        m_ready;
    logic [2:0]  level;
    logic [15:0] tok_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] exp_q [$];
    logic       drv_done;
    logic       rnd_done;
    logic       ack_prev;

    hs4_rx_sync #(
        .DATA_W      (3),
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hs_req  (hs_req),
        .hs_data (hs_data),
        .hs_ack  (hs_ack),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .level   (level),
        .tok_cnt (tok_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, input string tag);
        int n = 0;
        while (hs_ack !== val && n < 60) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(hs_ack), 32'(val));
    endtask

    task automatic send_token(input logic [2:0] d);
        hs_data = d;
        hs_req  = 1'b1;
        wait_ack(1'b1, "tok_ack");
        hs_req = 1'b0;
        wait_ack(1'b0, "tok_rel");
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        hs_req   = 1'b0;
        hs_data  = '0;
        m_ready  = 1'b0;
        drv_done = 1'b0;
        rnd_done = 1'b0;
        ack_prev = 1'b0;
        step(2);
        check_eq("rst_ack", 32'(hs_ack), 0);
        check_eq("rst_valid", 32'(m_valid), 0);
        check_eq("rst_data", 32'(m_data), 0);
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_tokcnt", 32'(tok_cnt), 0);
        rst = 1'b0;
        step(4);

        // Single token: ack three edges after req rises, drops three edges after req falls.
        hs_data = 3'b101;
        hs_req  = 1'b1;
        step(2);
        check_eq("single_ack_early", 32'(hs_ack), 0);
        step(1);
        check_eq("single_ack", 32'(hs_ack), 1);
        check_eq("single_valid", 32'(m_valid), 1);
        check_eq("single_data", 32'(m_data), 5);
        check_eq("single_level", 32'(level), 1);
        check_eq("single_tokcnt", 32'(tok_cnt), 1);
        hs_req = 1'b0;
        step(2);
        check_eq("single_ack_hold", 32'(hs_ack), 1);
        step(1);
        check_eq("single_ack_fall", 32'(hs_ack), 0);
        pop_one();
        check_eq("single_pop_level", 32'(level), 0);
        check_eq("single_pop_valid", 32'(m_valid), 0);
        m_ready = 1'b1;
        step(2);
        m_ready = 1'b0;
        check_eq("empty_pop_level", 32'(level), 0);

        // Fill: four tokens fit, the fifth is held off until a pop frees a slot.
        for (int d = 1; d <= 4; d++) send_token(3'(d));
        check_eq("fill_level", 32'(level), 4);
        hs_data = 3'd5;
        hs_req  = 1'b1;
        step(8);
        check_eq("full_no_ack", 32'(hs_ack), 0);
        check_eq("full_level", 32'(level), 4);
        check_eq("full_head", 32'(m_data), 1);
        pop_one();
        check_eq("full_pop_level", 32'(level), 3);
        wait_ack(1'b1, "full_late_ack");
        check_eq("full_refill_level", 32'(level), 4);
        hs_req = 1'b0;
        wait_ack(1'b0, "full_late_rel");
        for (int k = 2; k <= 5; k++) begin
            check_eq("fill_order", 32'(m_data), 32'(k));
            pop_one();
        end
        check_eq("fill_drain_level", 32'(level), 0);
        check_eq("fill_tokcnt", 32'(tok_cnt), 6);

        // Concurrent push and pop at level 2.
        send_token(3'd6);
        send_token(3'd7);
        check_eq("conc_level_pre", 32'(level), 2);
        hs_data = 3'd3;
        hs_req  = 1'b1;
        step(2);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        check_eq("conc_ack", 32'(hs_ack), 1);
        check_eq("conc_level", 32'(level), 2);
        check_eq("conc_head", 32'(m_data), 7);
        hs_req = 1'b0;
        wait_ack(1'b0, "conc_rel");
        pop_one();
        check_eq("conc_order", 32'(m_data), 3);
        pop_one();
        check_eq("conc_tokcnt", 32'(tok_cnt), 9);

        // Reset while holding ack with req still high.
        hs_data = 3'd2;
        hs_req  = 1'b1;
        wait_ack(1'b1, "rsthold_ack");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("rsthold_ack_drop", 32'(hs_ack), 0);
        check_eq("rsthold_level", 32'(level), 0);
        check_eq("rsthold_valid", 32'(m_valid), 0);
        check_eq("rsthold_tokcnt", 32'(tok_cnt), 0);
        step(10);
        check_eq("arm_no_ack", 32'(hs_ack), 0);
        check_eq("arm_level", 32'(level), 0);
        hs_req = 1'b0;
        step(4);
        hs_data = 3'd4;
        hs_req  = 1'b1;
        wait_ack(1'b1, "rearm_ack");
        check_eq("rearm_level", 32'(level), 1);
        check_eq("rearm_data", 32'(m_data), 4);
        check_eq("rearm_tokcnt", 32'(tok_cnt), 1);
        hs_req = 1'b0;
        wait_ack(1'b0, "rearm_rel");
        pop_one();

        // Random jittered handshakes against a scoreboard, with random consumer stalls.
        fork
            begin : driver
                for (int i = 0; i < 40; i++) begin
                    int n;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    #($urandom_range(1, 4));
                    hs_data = 3'($urandom_range(0, 7));
                    hs_req  = 1'b1;
                    n = 0;
                    while (!hs_ack && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    check_eq("rnd_ack", 32'(hs_ack), 1);
                    if (hs_ack) exp_q.push_back(hs_data);
                    #($urandom_range(1, 4));
                    hs_req = 1'b0;
                    n = 0;
                    while (hs_ack && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    check_eq("rnd_rel", 32'(hs_ack), 0);
                end
                drv_done = 1'b1;
            end
            begin : consumer
                int cyc = 0;
                while (!(drv_done && exp_q.size() == 0) && cyc < 20000) begin
                    @(posedge clk);
                    #1 m_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    #1;
                    if (m_valid && m_ready) begin
                        if (exp_q.size() > 0) check_eq("rnd_data", 32'(m_data), 32'(exp_q.pop_front()));
                        else check_eq("rnd_dup", 32'(m_valid), 0);
                    end
                    cyc++;
                end
                m_ready  = 1'b0;
                rnd_done = 1'b1;
            end
            begin : monitor
                while (!rnd_done) begin
                    @(negedge clk);
                    if (hs_ack && !ack_prev) check_eq("ph_rise", 32'(hs_req), 1);
                    if (!hs_ack && ack_prev) check_eq("ph_fall", 32'(hs_req), 0);
                    ack_prev = hs_ack;
                end
            end
        join
        step(2);
        check_eq("rnd_scoreboard_empty", 32'(exp_q.size()), 0);
        check_eq("rnd_level", 32'(level), 0);
        check_eq("rnd_tokcnt", 32'(tok_cnt), 41);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
